// File: rtl/sample_stream_tx_if.sv
// Purpose  : valid/ready sample stream feeding sample_stream_tx.
// Latency  : pure wiring; no storage.
// Backpres.: o_ready low stalls the source; a word moves only when i_valid & o_ready.
// Ports    : i_sample (signed sample), i_valid (sample valid) driven by the source;
//            o_ready (transmitter can accept) driven by the transmitter.
interface sample_stream_tx_if #(
   parameter int BITS_PER_ELEM = 8
);
   logic signed [BITS_PER_ELEM-1:0] i_sample;
   logic                            i_valid;
   logic                            o_ready;

   modport master (output i_sample, output i_valid, input o_ready);
   modport slave  (input i_sample, input i_valid, output o_ready);
endinterface

// File: rtl/sample_stream_tx.sv
// Purpose  : buffers samples in a small FIFO and serialises each onto o_value with an
//            o_data_clk strobe (value set up, strobe pulsed, value held) for a shift-register line.
// Latency  : push into an empty idle FIFO at edge N -> o_value at N+1, strobe rises at N+1+SETUP_CYCLES.
// Backpres.: o_ready drops when the FIFO is full; i_enable low lets the word in flight finish, then idles.
// Ports    : clk, rst (async, active-low); i_src (sample/valid/ready stream, slave side);
//            i_enable (allow new transfers); i_period (requested clocks between strobe rises);
//            o_value/o_data_clk (to core i_value/i_data_clk); o_level (FIFO occupancy);
//            o_busy (transfer in progress); o_underrun (sticky starvation flag while enabled).
module sample_stream_tx #(
   parameter int BITS_PER_ELEM = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int SETUP_CYCLES  = 2,
   parameter int HIGH_CYCLES   = 2,
   parameter int LOW_CYCLES    = 2,
   parameter int PERIOD_W      = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   sample_stream_tx_if.slave                 i_src,
   input  logic                              i_enable,
   input  logic [PERIOD_W-1:0]               i_period,
   output logic signed [BITS_PER_ELEM-1:0]   o_value,
   output logic                              o_data_clk,
   output logic [$clog2(FIFO_DEPTH):0]       o_level,
   output logic                              o_busy,
   output logic                              o_underrun
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = AW + 1;
   localparam int MIN_P = SETUP_CYCLES + HIGH_CYCLES + LOW_CYCLES;
   // Counter must hold both the largest requested period and the minimum word time.
   localparam int CW    = ((PERIOD_W > $clog2(MIN_P + 1)) ? PERIOD_W : $clog2(MIN_P + 1)) + 1;

   localparam logic [CW-1:0] C_SETUP_END = CW'(SETUP_CYCLES);
   localparam logic [CW-1:0] C_HIGH_END  = CW'(SETUP_CYCLES + HIGH_CYCLES);
   localparam logic [CW-1:0] C_MIN_P     = CW'(MIN_P);
   localparam logic [LW-1:0] C_FULL      = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [BITS_PER_ELEM-1:0]        r_mem [FIFO_DEPTH];
   logic [AW-1:0]                   r_wr_ptr;
   logic [AW-1:0]                   r_rd_ptr;
   logic [LW-1:0]                   r_level;
   logic                            r_ready;

   // Transfer state
   state_t                          r_state;
   logic [CW-1:0]                   r_cnt;
   logic [CW-1:0]                   r_period;
   logic signed [BITS_PER_ELEM-1:0] r_value;
   logic                            r_data_clk;
   logic                            r_underrun;

   state_t                          w_state_nxt;
   logic                            w_push;
   logic                            w_pop;
   logic                            w_empty;
   logic                            w_low_done;
   logic                            w_starve;
   logic                            w_data_clk_nxt;
   logic                            w_busy;
   logic [LW-1:0]                   w_level_nxt;
   logic [CW-1:0]                   w_period_ext;
   logic [CW-1:0]                   w_period_eff;

   assign w_empty      = (r_level == '0);
   assign w_push       = i_src.i_valid & r_ready;
   assign w_period_ext = CW'(i_period);
   // Short requests are stretched so every word gets its full setup/high/low windows.
   assign w_period_eff = (w_period_ext > C_MIN_P) ? w_period_ext : C_MIN_P;

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + 1'b1;
         2'b01:   w_level_nxt = r_level - 1'b1;
         default: w_level_nxt = r_level;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state. r_cnt counts clocks since the pop that started the word,
   // so each window boundary is a fixed count and the period check is cnt >= P.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_low_done  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_enable && !w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (r_cnt == C_SETUP_END) w_state_nxt = ST_HIGH;
         end
         ST_HIGH: begin
            if (r_cnt == C_HIGH_END) w_state_nxt = ST_LOW;
         end
         ST_LOW: begin
            // r_period >= MIN_P, so this also guarantees LOW_CYCLES clocks in LOW.
            if (r_cnt >= r_period) begin
               w_low_done = 1'b1;
               if (i_enable && !w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = ST_SETUP;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_busy         = (r_state != ST_IDLE);
      w_data_clk_nxt = (w_state_nxt == ST_HIGH);
      w_starve       = w_low_done & i_enable & w_empty;
   end

   // FIFO storage is not reset; only occupancy decides what is readable.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_src.i_sample;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_ready    <= 1'b1;
         r_cnt      <= '0;
         r_period   <= C_MIN_P;
         r_value    <= '0;
         r_data_clk <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;

         // Period is latched at pop so later i_period changes leave the word in flight alone.
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_value  <= r_mem[r_rd_ptr];
            r_cnt    <= CW'(1);
            r_period <= w_period_eff;
         end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
         end

         r_level    <= w_level_nxt;
         r_ready    <= (w_level_nxt != C_FULL);
         r_data_clk <= w_data_clk_nxt;

         if (!i_enable)     r_underrun <= 1'b0;
         else if (w_starve) r_underrun <= 1'b1;
      end
   end

   assign i_src.o_ready = r_ready;
   assign o_value       = r_value;
   assign o_data_clk    = r_data_clk;
   assign o_level       = r_level;
   assign o_busy        = w_busy;
   assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_sample_stream_tx.sv
// Purpose  : self-checking bench for sample_stream_tx against a queue/timing reference model.
// Latency  : n/a (testbench).
// Backpres.: source side honours o_ready; every wait on the DUT is cycle-bounded.
module tb_sample_stream_tx;
   localparam int W     = 8;
   localparam int SETUP = 2;
   localparam int HIGH  = 2;
   localparam int LOW   = 2;
   localparam int MIN_P = SETUP + HIGH + LOW;

   logic                clk = 1'b0;
   logic                rst;
   logic                i_enable;
   logic [15:0]         i_period;
   logic signed [W-1:0] o_value;
   logic                o_data_clk;
   logic [2:0]          o_level;
   logic                o_busy;
   logic                o_underrun;

   always #5 clk = ~clk;

   sample_stream_tx_if #(.BITS_PER_ELEM(W)) src_if ();

   sample_stream_tx #(
      .BITS_PER_ELEM(W), .FIFO_DEPTH(4), .SETUP_CYCLES(SETUP),
      .HIGH_CYCLES(HIGH), .LOW_CYCLES(LOW), .PERIOD_W(16)
   ) dut (
      .clk(clk), .rst(rst), .i_src(src_if), .i_enable(i_enable), .i_period(i_period),
      .o_value(o_value), .o_data_clk(o_data_clk), .o_level(o_level),
      .o_busy(o_busy), .o_underrun(o_underrun)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state: words accepted by the source, and what the core would capture.
   logic [W-1:0] push_q [$];
   logic [W-1:0] rise_val [$];
   int           rise_cyc [$];
   int           hi_len_q [$];
   int           hi_len;
   int           hold_viol;
   logic         prev_clk;
   logic [W-1:0] prev_val;

   // Core-side observer: captures o_value on each strobe rising edge, as the shift line would.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         prev_clk = 1'b0;
         prev_val = o_value;
         hi_len   = 0;
      end else begin
         if (o_data_clk && !prev_clk) begin
            rise_cyc.push_back(cyc);
            rise_val.push_back(o_value);
            hi_len = 0;
         end
         if (o_data_clk) hi_len++;
         if (!o_data_clk && prev_clk) hi_len_q.push_back(hi_len);
         if (o_value !== prev_val && (o_data_clk || prev_clk)) hold_viol++;
         prev_clk = o_data_clk;
         prev_val = o_value;
      end
   end

   function automatic int eff_period(input int p);
      return (p > MIN_P) ? p : MIN_P;
   endfunction

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_obs();
      push_q.delete(); rise_val.delete(); rise_cyc.delete(); hi_len_q.delete();
      hold_viol = 0;
   endtask

   task automatic push_word(input logic [W-1:0] d);
      int t = 0;
      src_if.i_sample = d;
      src_if.i_valid  = 1'b1;
      while (src_if.o_ready !== 1'b1 && t < 400) begin step(1); t++; end
      step(1);
      src_if.i_valid = 1'b0;
      checks++;
      if (t >= 400) begin
         errors++;
         $display("FAIL push_accept: o_ready=%b after %0d cycles, need 1", src_if.o_ready, t);
      end else begin
         push_q.push_back(d);
      end
   endtask

   task automatic wait_rises(input int n, input string tag);
      int t = 0;
      while (rise_val.size() < n && t < 2000) begin step(1); t++; end
      checks++;
      if (rise_val.size() < n) begin
         errors++;
         $display("FAIL %s rise_count: got %0d, need %0d", tag, rise_val.size(), n);
      end
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (o_busy !== 1'b0 && t < 500) begin step(1); t++; end
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: o_busy=%b after %0d cycles, need 0", tag, o_busy, t);
      end
   endtask

   task automatic test_reset();
      int t = 0;
      rst = 1'b0; i_enable = 1'b0; i_period = '0;
      src_if.i_valid = 1'b0; src_if.i_sample = '0;
      step(3);
      checks++;
      if ({o_data_clk, o_level, o_busy, o_underrun, o_value} !== '0) begin
         errors++;
         $display("FAIL reset_state: clk=%b lvl=%0d busy=%b und=%b val=%h, need all 0",
                  o_data_clk, o_level, o_busy, o_underrun, o_value);
      end
      rst = 1'b1;
      step(1);
      checks++;
      if (src_if.o_ready !== 1'b1 || o_level !== 3'd0) begin
         errors++;
         $display("FAIL reset_release: ready=%b lvl=%0d, need 1/0", src_if.o_ready, o_level);
      end
      // Reset in the middle of the strobe pulse.
      clear_obs();
      i_enable = 1'b1;
      push_word(8'h5A);
      while (o_data_clk !== 1'b1 && t < 50) begin step(1); t++; end
      checks++;
      if (o_data_clk !== 1'b1) begin
         errors++;
         $display("FAIL reset_reach_high: o_data_clk=%b, need 1", o_data_clk);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (o_data_clk !== 1'b0 || o_busy !== 1'b0 || o_level !== 3'd0 || o_value !== '0) begin
         errors++;
         $display("FAIL reset_mid_high: clk=%b busy=%b lvl=%0d val=%h, need 0/0/0/00",
                  o_data_clk, o_busy, o_level, o_value);
      end
      @(posedge clk); #1;
      rst = 1'b1; i_enable = 1'b0;
      step(2);
      checks++;
      if (src_if.o_ready !== 1'b1 || o_level !== 3'd0 || o_data_clk !== 1'b0) begin
         errors++;
         $display("FAIL reset_after: ready=%b lvl=%0d clk=%b, need 1/0/0",
                  src_if.o_ready, o_level, o_data_clk);
      end
   endtask

   task automatic test_single();
      int push_c;
      clear_obs();
      i_period = 16'd0; i_enable = 1'b1;
      push_word(8'h9C);
      push_c = cyc;
      checks++;
      if (o_level !== 3'd1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL single_push: lvl=%0d busy=%b, need 1/0", o_level, o_busy);
      end
      for (int j = 0; j < 8; j++) begin
         step(1);
         checks++;
         if (o_value !== 8'h9C || o_data_clk !== (j == SETUP || j == SETUP + 1)
             || o_busy !== (j < MIN_P)) begin
            errors++;
            $display("FAIL single_t%0d: val=%h clk=%b busy=%b, need 9c/%b/%b", j, o_value,
                     o_data_clk, o_busy, (j == SETUP || j == SETUP + 1), (j < MIN_P));
         end
      end
      checks++;
      if (rise_val.size() != 1 || $signed(rise_val[0]) !== -100 || rise_cyc[0] - push_c != 1 + SETUP) begin
         errors++;
         $display("FAIL single_capture: n=%0d val=%0d dt=%0d, need 1/-100/%0d", rise_val.size(),
                  (rise_val.size() > 0) ? $signed(rise_val[0]) : 0,
                  (rise_cyc.size() > 0) ? rise_cyc[0] - push_c : -1, 1 + SETUP);
      end
      checks++;
      if (o_underrun !== 1'b1) begin
         errors++;
         $display("FAIL single_underrun_set: o_underrun=%b, need 1", o_underrun);
      end
      i_enable = 1'b0;
      step(1);
      checks++;
      if (o_underrun !== 1'b0) begin
         errors++;
         $display("FAIL single_underrun_clr: o_underrun=%b, need 0", o_underrun);
      end
   endtask

   task automatic test_stream();
      clear_obs();
      i_period = 16'd10; i_enable = 1'b1;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               push_word(W'(i));
               step($urandom_range(0, 3));
            end
         end
         wait_rises(16, "stream");
      join
      checks++;
      if (o_underrun !== 1'b0) begin
         errors++;
         $display("FAIL stream_underrun: o_underrun=%b, need 0", o_underrun);
      end
      i_enable = 1'b0;
      wait_idle("stream");
      for (int i = 0; i < 16 && i < rise_val.size(); i++) begin
         checks++;
         if (rise_val[i] !== push_q[i]) begin
            errors++;
            $display("FAIL stream_val%0d: got %h, need %h", i, rise_val[i], push_q[i]);
         end
         if (i > 0) begin
            checks++;
            if (rise_cyc[i] - rise_cyc[i-1] != eff_period(10)) begin
               errors++;
               $display("FAIL stream_gap%0d: got %0d, need %0d", i, rise_cyc[i] - rise_cyc[i-1], eff_period(10));
            end
         end
      end
      checks++;
      if (hold_viol != 0) begin
         errors++;
         $display("FAIL stream_hold: value changed near strobe %0d times, need 0", hold_viol);
      end
   endtask

   task automatic test_fill();
      clear_obs();
      i_period = 16'd0; i_enable = 1'b0;
      for (int k = 0; k < 4; k++) push_word(W'($urandom));
      checks++;
      if (src_if.o_ready !== 1'b0 || o_level !== 3'd4) begin
         errors++;
         $display("FAIL fill_full: ready=%b lvl=%0d, need 0/4", src_if.o_ready, o_level);
      end
      src_if.i_sample = W'($urandom);
      src_if.i_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1);
         checks++;
         if (o_level !== 3'd4 || src_if.o_ready !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_ignore%0d: lvl=%0d ready=%b busy=%b, need 4/0/0", k, o_level,
                     src_if.o_ready, o_busy);
         end
      end
      src_if.i_valid = 1'b0;
      i_enable = 1'b1;
      wait_rises(4, "fill");
      wait_idle("fill");
      checks++;
      if (rise_val.size() != 4 || o_level !== 3'd0) begin
         errors++;
         $display("FAIL fill_count: strobes=%0d lvl=%0d, need 4/0", rise_val.size(), o_level);
      end
      for (int i = 0; i < 4 && i < rise_val.size(); i++) begin
         checks++;
         if (rise_val[i] !== push_q[i] || (i > 0 && rise_cyc[i] - rise_cyc[i-1] != eff_period(0))) begin
            errors++;
            $display("FAIL fill_word%0d: got %h, need %h", i, rise_val[i], push_q[i]);
         end
      end
      i_enable = 1'b0;
      step(1);
   endtask

   task automatic test_wrap();
      logic [W-1:0] w;
      clear_obs();
      i_period = 16'd0; i_enable = 1'b0;
      push_word(W'($urandom));
      push_word(W'($urandom));
      w = W'($urandom);
      checks++;
      if (o_level !== 3'd2 || src_if.o_ready !== 1'b1) begin
         errors++;
         $display("FAIL wrap_pre: lvl=%0d ready=%b, need 2/1", o_level, src_if.o_ready);
      end
      src_if.i_sample = w; src_if.i_valid = 1'b1; i_enable = 1'b1;
      step(1);
      src_if.i_valid = 1'b0;
      push_q.push_back(w);
      checks++;
      if (o_level !== 3'd2 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL wrap_pushpop: lvl=%0d busy=%b, need 2/1", o_level, o_busy);
      end
      wait_rises(3, "wrap0");
      wait_idle("wrap0");
      for (int f = 0; f < 3; f++) begin
         i_enable = 1'b0;
         step(1);
         for (int k = 0; k < 4; k++) push_word(W'($urandom));
         checks++;
         if (o_level !== 3'd4 || src_if.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrap_fill%0d: lvl=%0d ready=%b, need 4/0", f, o_level, src_if.o_ready);
         end
         i_enable = 1'b1;
         wait_rises(3 + 4 * (f + 1), "wrap");
         wait_idle("wrap");
      end
      checks++;
      if (rise_val.size() != 15) begin
         errors++;
         $display("FAIL wrap_count: strobes=%0d, need 15", rise_val.size());
      end
      for (int i = 0; i < 15 && i < rise_val.size(); i++) begin
         checks++;
         if (rise_val[i] !== push_q[i]) begin
            errors++;
            $display("FAIL wrap_val%0d: got %h, need %h", i, rise_val[i], push_q[i]);
         end
         if (i > 0 && (i % 4) != 3) begin
            checks++;
            if (rise_cyc[i] - rise_cyc[i-1] != eff_period(0)) begin
               errors++;
               $display("FAIL wrap_gap%0d: got %0d, need %0d", i, rise_cyc[i] - rise_cyc[i-1], eff_period(0));
            end
         end
      end
      i_enable = 1'b0;
      step(1);
   endtask

   task automatic test_period();
      int exp_gap [3];
      clear_obs();
      exp_gap[0] = eff_period(12); exp_gap[1] = eff_period(20); exp_gap[2] = eff_period(3);
      i_period = 16'd12; i_enable = 1'b0;
      for (int k = 0; k < 4; k++) push_word(W'($urandom));
      i_enable = 1'b1;
      wait_rises(1, "period1");
      i_period = 16'd20;
      wait_rises(2, "period2");
      i_period = 16'd3;
      wait_rises(4, "period4");
      for (int i = 1; i < 4 && i < rise_val.size(); i++) begin
         checks++;
         if (rise_cyc[i] - rise_cyc[i-1] != exp_gap[i-1] || rise_val[i] !== push_q[i]) begin
            errors++;
            $display("FAIL period_gap%0d: gap=%0d val=%h, need %0d/%h", i, rise_cyc[i] - rise_cyc[i-1],
                     rise_val[i], exp_gap[i-1], push_q[i]);
         end
      end
      i_enable = 1'b0;
      wait_idle("period");
   endtask

   task automatic test_enable_drop();
      clear_obs();
      i_period = 16'd0; i_enable = 1'b0;
      push_word(W'($urandom));
      push_word(W'($urandom));
      i_enable = 1'b1;
      step(1);
      checks++;
      if (o_busy !== 1'b1 || o_level !== 3'd1 || o_value !== push_q[0]) begin
         errors++;
         $display("FAIL drop_pop: busy=%b lvl=%0d val=%h, need 1/1/%h", o_busy, o_level, o_value, push_q[0]);
      end
      i_enable = 1'b0;
      for (int j = 1; j < 8; j++) begin
         step(1);
         checks++;
         if (o_data_clk !== (j == SETUP || j == SETUP + 1) || o_busy !== (j < MIN_P)) begin
            errors++;
            $display("FAIL drop_t%0d: clk=%b busy=%b, need %b/%b", j, o_data_clk, o_busy,
                     (j == SETUP || j == SETUP + 1), (j < MIN_P));
         end
      end
      checks++;
      if (o_level !== 3'd1 || rise_val.size() != 1 || hi_len_q.size() != 1
          || (hi_len_q.size() > 0 && hi_len_q[0] != HIGH)) begin
         errors++;
         $display("FAIL drop_complete: lvl=%0d strobes=%0d pulses=%0d, need 1/1/1 of %0d clocks",
                  o_level, rise_val.size(), hi_len_q.size(), HIGH);
      end
      i_enable = 1'b1;
      wait_rises(2, "starve");
      checks++;
      if (o_underrun !== 1'b0) begin
         errors++;
         $display("FAIL starve_early: o_underrun=%b, need 0", o_underrun);
      end
      wait_idle("starve");
      checks++;
      if (o_underrun !== 1'b1 || o_level !== 3'd0) begin
         errors++;
         $display("FAIL starve_set: und=%b lvl=%0d, need 1/0", o_underrun, o_level);
      end
      step(3);
      checks++;
      if (o_underrun !== 1'b1) begin
         errors++;
         $display("FAIL starve_sticky: o_underrun=%b, need 1", o_underrun);
      end
      i_enable = 1'b0;
      step(1);
      checks++;
      if (o_underrun !== 1'b0) begin
         errors++;
         $display("FAIL starve_clear: o_underrun=%b, need 0", o_underrun);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_fill();
      test_wrap();
      test_period();
      test_enable_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end
endmodule
